// File: rtl/rca_addsub_if.sv
// rtl/rca_addsub_if.sv - operand/result handshake bundle for the pipelined adder/subtractor
interface rca_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Operand producer and result consumer side
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Arithmetic block side
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_addsub_pipe.sv
// rtl/rca_addsub_pipe.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
module rca_addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    rca_addsub_if.slave  io
);
    localparam int SEG = WIDTH / STAGES;

    if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("rca_addsub_pipe: WIDTH must be >= 2 and divisible by STAGES");
    end

    // Per-stage registers: valid bit, skew-delayed operands, completed low slices, segment carry
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic              ovf_q, ovf_d;

    // Inputs seen by each stage's segment adder
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_r [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    logic              en;
    logic              rc;
    logic              rc_msb;
    logic [WIDTH-1:0]  rsum;

    // Whole pipeline advances unless a finished result is waiting on the consumer
    assign en           = !(vld_q[STAGES-1] && !io.out_ready);
    assign io.in_ready  = en;
    assign io.out_valid = vld_q[STAGES-1];
    assign io.sum       = res_q[STAGES-1];
    assign io.cout      = cry_q[STAGES-1];
    assign io.ovf       = ovf_q;

    // Stage 0 takes the ports (b inverted and cin=1 for subtract); later stages take the previous register
    always_comb begin
        st_a[0] = io.a;
        st_b[0] = io.sub ? ~io.b : io.b;
        st_c[0] = io.sub;
        st_r[0] = '0;
        st_v[0] = io.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = opa_q[k-1];
            st_b[k] = opb_q[k-1];
            st_c[k] = cry_q[k-1];
            st_r[k] = res_q[k-1];
            st_v[k] = vld_q[k-1];
        end
    end

    // Ripple each stage's segment and compute next register contents; data only loads with a valid slot
    always_comb begin
        vld_d  = vld_q;
        cry_d  = cry_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        rc     = 1'b0;
        rc_msb = 1'b0;
        rsum   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (en) begin
                vld_d[k] = st_v[k];
            end
            rc   = st_c[k];
            rsum = st_r[k];
            for (int i = 0; i < SEG; i++) begin
                rc_msb             = rc;
                rsum[k*SEG + i]    = st_a[k][k*SEG + i] ^ st_b[k][k*SEG + i] ^ rc;
                rc                 = (st_a[k][k*SEG + i] & st_b[k][k*SEG + i])
                                   | (rc & (st_a[k][k*SEG + i] ^ st_b[k][k*SEG + i]));
            end
            if (en && st_v[k]) begin
                opa_d[k] = st_a[k];
                opb_d[k] = st_b[k];
                res_d[k] = rsum;
                cry_d[k] = rc;
                if (k == STAGES - 1) begin
                    // rc_msb holds the carry into the MSB after the last iteration
                    ovf_d = rc_msb ^ rc;
                end
            end
        end
    end

    // Pipeline registers; reset drops all in-flight work and clears the visible result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end
endmodule

// File: tb/tb_rca_addsub_pipe.sv
// tb/tb_rca_addsub_pipe.sv - self-checking bench for rca_addsub_pipe against an arithmetic model
module tb_rca_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rca_addsub_if #(.WIDTH(8))  io8 ();
    rca_addsub_if #(.WIDTH(16)) io16 ();

    rca_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io8)
    );

    rca_addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io16)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q [$];
    logic       held;
    logic [9:0] held_v;
    logic [9:0] e;
    logic [9:0] m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic; returns {cout, ovf, sum}
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ua, ub, full, sa, sb, sr;
        logic [7:0] sm;
        logic       co, ov;
        ua   = int'(a);
        ub   = int'(b);
        full = s ? (ua + 256 - ub) : (ua + ub);
        sm   = 8'(full % 256);
        co   = (full >= 256);
        sa   = (ua >= 128) ? ua - 256 : ua;
        sb   = (ub >= 128) ? ub - 256 : ub;
        sr   = s ? (sa - sb) : (sa + sb);
        ov   = (sr > 127) || (sr < -128);
        return {co, ov, sm};
    endfunction

    // Scoreboard: handshakes decided at the coming edge are visible at the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(io8.out_valid), 32'd1);
                chk("hold_value", 32'({io8.cout, io8.ovf, io8.sum}), 32'(held_v));
            end
            held   = io8.out_valid && !io8.out_ready;
            held_v = {io8.cout, io8.ovf, io8.sum};
            if (io8.out_valid && io8.out_ready) begin
                chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result", 32'({io8.cout, io8.ovf, io8.sum}), 32'(e));
                end
            end
            if (io8.in_valid && io8.in_ready) begin
                exp_q.push_back(ref8(io8.a, io8.b, io8.sub));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (exp_q.size() != 0 || io8.out_valid); i++) begin
            step();
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] pick8();
        logic [7:0] corners [5];
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'hFF;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return 8'($urandom());
    endfunction

    initial begin
        rst_n         = 1'b1;
        io8.in_valid  = 1'b0;  io8.a  = '0; io8.b  = '0; io8.sub  = 1'b0; io8.out_ready  = 1'b1;
        io16.in_valid = 1'b0;  io16.a = '0; io16.b = '0; io16.sub = 1'b0; io16.out_ready = 1'b1;

        // Model pinned to hand-computed values
        m = ref8(8'h7F, 8'h01, 1'b0); chk("model_7f_plus_1", 32'(m), 32'h180 >> 1 << 1 | 32'h080);
        m = ref8(8'h05, 8'h07, 1'b1); chk("model_5_minus_7", 32'(m), 32'h0FE);
        m = ref8(8'h80, 8'h01, 1'b1); chk("model_80_minus_1", 32'(m), 32'h37F);
        m = ref8(8'h00, 8'h01, 1'b1); chk("model_0_minus_1", 32'(m), 32'h0FF);
        m = ref8(8'hFF, 8'h01, 1'b0); chk("model_ff_plus_1", 32'(m), 32'h200);

        // Reset state, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(io8.out_valid), 32'd0);
        chk("rst_sum",       32'(io8.sum),       32'd0);
        chk("rst_cout",      32'(io8.cout),      32'd0);
        chk("rst_ovf",       32'(io8.ovf),       32'd0);
        chk("rst_in_ready",  32'(io8.in_ready),  32'd1);
        chk("rst16_out_valid", 32'(io16.out_valid), 32'd0);
        chk("rst16_in_ready",  32'(io16.in_ready),  32'd1);
        step(); step();
        rst_n = 1'b1;
        step();

        // Add with signed overflow; latency of two edges including the accept edge
        io8.in_valid = 1'b1; io8.a = 8'h7F; io8.b = 8'h01; io8.sub = 1'b0;
        step();
        io8.in_valid = 1'b0;
        chk("t1_not_yet_valid", 32'(io8.out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(io8.out_valid), 32'd1);
        chk("t1_value", 32'({io8.cout, io8.ovf, io8.sum}), 32'h180);
        step();

        // Back-to-back subtracts with borrow and with overflow
        io8.in_valid = 1'b1; io8.a = 8'h05; io8.b = 8'h07; io8.sub = 1'b1;
        step();
        io8.a = 8'h80; io8.b = 8'h01;
        step();
        io8.in_valid = 1'b0;
        chk("t2a_value", 32'({io8.out_valid, io8.cout, io8.ovf, io8.sum}), 32'h4FE);
        step();
        chk("t2b_value", 32'({io8.out_valid, io8.cout, io8.ovf, io8.sum}), 32'h77F);
        drain();

        // Full pipe with consumer stalled: input blocked, output held
        io8.out_ready = 1'b0;
        io8.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io8.a = pick8(); io8.b = pick8(); io8.sub = 1'($urandom());
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(io8.in_ready), 32'd0);
            step();
        end
        io8.in_valid  = 1'b0;
        io8.out_ready = 1'b1;
        drain();

        // Continuous traffic: one result per cycle once the pipe is full
        io8.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            io8.a = pick8(); io8.b = pick8(); io8.sub = 1'($urandom());
            step();
            if (i >= 2) chk("b2b_out_valid", 32'(io8.out_valid), 32'd1);
        end
        io8.in_valid = 1'b0;
        drain();

        // Random stalls on both sides
        for (int i = 0; i < 3000; i++) begin
            io8.in_valid  = ($urandom_range(0, 3) != 0);
            io8.out_ready = ($urandom_range(0, 3) != 0);
            io8.a = pick8(); io8.b = pick8(); io8.sub = 1'($urandom());
            step();
        end
        io8.in_valid  = 1'b0;
        io8.out_ready = 1'b1;
        drain();

        // Reset with two transactions in flight, then a fresh one after release
        io8.in_valid = 1'b1; io8.a = 8'h11; io8.b = 8'h22; io8.sub = 1'b0;
        step();
        io8.a = 8'h33; io8.b = 8'h44;
        step();
        io8.in_valid = 1'b0;
        chk("t5_in_flight", 32'(io8.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(io8.out_valid), 32'd0);
        chk("t5_rst_sum",       32'(io8.sum),       32'd0);
        chk("t5_rst_cout_ovf",  32'({io8.cout, io8.ovf}), 32'd0);
        step();
        rst_n = 1'b1;
        io8.in_valid = 1'b1; io8.a = 8'hF0; io8.b = 8'h20; io8.sub = 1'b1;
        step();
        io8.in_valid = 1'b0;
        chk("t5_new_not_yet", 32'(io8.out_valid), 32'd0);
        step();
        chk("t5_new_value", 32'({io8.out_valid, io8.cout, io8.ovf, io8.sum}), 32'h6D0);
        drain();

        // Wide configuration: 16 bits over four segments
        io16.in_valid = 1'b1; io16.a = 16'hFFFF; io16.b = 16'h0001; io16.sub = 1'b0;
        step();
        io16.a = 16'h8000; io16.b = 16'h0001; io16.sub = 1'b1;
        step();
        io16.in_valid = 1'b0;
        chk("t6_lat_n1", 32'(io16.out_valid), 32'd0);
        step();
        chk("t6_lat_n2", 32'(io16.out_valid), 32'd0);
        step();
        chk("t6a_value", 32'({io16.out_valid, io16.cout, io16.ovf, io16.sum}), 32'h60000);
        step();
        chk("t6b_value", 32'({io16.out_valid, io16.cout, io16.ovf, io16.sum}), 32'h77FFF);
        step();
        chk("t6_empty", 32'(io16.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
